dsi_lanes_sequencer: RTL and testbench
======================================

# dsi_lanes_sequencer

Parametrised power-up and HS-burst sequencer for a DSI PHY with `LANES` data lanes plus one clock lane. It drives the control inputs of the per-lane serialisers and the clock-lane serialiser:
- LP buffer enables;
- clock-lane start/stop requests;
- synchronised HS start pulses.

It supports continuous and non-continuous (burst-gated) clock mode, with programmable T_CLK_PRE / T_CLK_POST intervals. It sits between the lane FIFOs' status flags and the lane instances, in the `clk_phy` domain.

## Interface
Parameters:
- `LANES`, default 4: number of data lanes, legal range 1..8.
- `TIMER_W`, default 8: width of timing registers and the internal countdown timer.

Ports:
- `clk_phy`  in  1: PHY logic clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `lines_enable`  in  1: request LP output buffers on.
- `clock_enable`  in  1: request clock lane active.
- `clk_continuous`  in  1: 1 = clock stays HS between bursts; 0 = clock stopped after each burst.
- `reg_lanes_number`  in  4: active lane count.
- `reg_t_clk_pre`  in  TIMER_W: wait after clock active before first data start.
- `reg_t_clk_post`  in  TIMER_W: wait after data end before clock stop.
- `lane_pending`  in  LANES: per-lane data available (FIFO not empty).
- `lane_active`  in  LANES: per-lane serialiser busy.
- `clk_active`  in  1: clock lane in HS.
- `lane_lines_enable`  out  LANES: per-lane LP buffer enable.
- `lane_start_rqst`  out  LANES: per-lane HS start pulse.
- `clk_lines_enable`  out  1: clock-lane LP buffer enable.
- `clk_start_rqst`  out  1: clock-lane start request.
- `clk_fin_rqst`  out  1: clock-lane stop request.
- `lines_ready`  out  1: LP buffers on.
- `clock_ready`  out  1: equals `clk_active`.
- `lines_active`  out  1: OR of `lane_active` over enabled lanes.

## Operation
- **Enable mask.** `mask` is a LANES-bit register. It is loaded in LP_ENABLE with lanes 0..n-1 set, where n = clamp(`reg_lanes_number`, 1, LANES); 0 is treated as 1 and values above LANES as LANES. `mask` is cleared in DISABLE.
- **Derived outputs.** `lane_lines_enable` = `mask`; `clk_lines_enable` = `lines_ready` = `mask[0]`.
- **Pending condition.** `all_pending` = &(`lane_pending` | ~`mask`). HS starts only when every enabled lane has data, so all lanes start in the same cycle.
- **Timer.** Loaded with the reg value on entry to CLK_PRE or CLK_POST. It decrements each cycle and the state exits when timer==0, so the state lasts reg+1 cycles.
- **`seen` flag.** Cleared in LANES_GO; set whenever any enabled `lane_active` is 1.

State transitions (registered state; next-state logic is combinational):
- **IDLE:** `lines_enable` -> LP_ENABLE.
- **LP_ENABLE:** -> LP_IDLE, unconditionally; `mask` loads.
- **LP_IDLE:** !`lines_enable` -> DISABLE; else `clock_enable` && (`clk_continuous` || `all_pending`) -> CLK_START.
- **CLK_START:** `clk_start_rqst`=1; `clk_active` -> CLK_PRE.
- **CLK_PRE:** timer==0 -> HS_READY.
- **HS_READY:** `clock_enable` && `all_pending` -> LANES_GO; else (!`clock_enable` || !`clk_continuous`) -> CLK_POST.
- **LANES_GO:** `lane_start_rqst` = `mask` for exactly this one cycle; -> LANES_WAIT.
- **LANES_WAIT:** `seen` && no enabled `lane_active` -> (`clock_enable` && `clk_continuous`) ? HS_READY : CLK_POST.
- **CLK_POST:** timer==0 -> CLK_STOP.
- **CLK_STOP:** `clk_fin_rqst`=1; !`clk_active` -> LP_IDLE.
- **DISABLE:** -> IDLE after one cycle.

Boundary rules:
- `clock_enable` dropping during LANES_GO or LANES_WAIT does not abort the burst; shutdown follows completion via CLK_POST.
- `lines_enable` dropping while the clock runs is ignored until the sequencer is back in LP_IDLE.
- `reg_lanes_number` changes take effect only at the next LP_ENABLE.
- Timer registers are sampled only on state entry.
- Unknown or illegal state encodings go to IDLE.

## Timing
- **Reset values.** All outputs 0, state IDLE, `mask` 0, timer 0, `seen` 0.
- **Enable latency.** `lines_enable` rising edge -> `lines_ready`=1 two cycles later (IDLE->LP_ENABLE, then mask registered).
- **Clock request.** `clk_start_rqst` is high from entry into CLK_START until the cycle `clk_active` is sampled 1.
- **Start latency.** The first `lane_start_rqst` comes `reg_t_clk_pre`+2 cycles after `clk_active` is sampled high, provided `all_pending` holds throughout.
- **Outputs.** All outputs are registered, or decoded from the registered state and `mask`; no combinational input-to-output path except `clock_ready` and `lines_active`.

## Test plan
- **Power-up with 2 lanes.** `reg_lanes_number`=2, pulse `lines_enable`=1 -> `lane_lines_enable`=4'b0011 two cycles later, `lines_ready`=1, clock outputs 0.
- **Continuous clock.** `clk_continuous`=1, `clock_enable`=1, `reg_t_clk_pre`=5 -> `clk_start_rqst` until `clk_active`; raise `lane_pending`=4'b1111 -> `lane_start_rqst`=4'b1111 for one cycle, 7 cycles after `clk_active`.
- **Partial pending.** `lane_pending`=4'b0111 with 4 lanes enabled -> no start; set bit 3 -> all four lanes start in the same cycle.
- **Non-continuous burst.** After lanes go active then idle -> CLK_POST lasts `reg_t_clk_post`+1 = 4 cycles (post=3), then `clk_fin_rqst` until `clk_active`=0, then a return to LP_IDLE.
- **Shutdown mid-burst.** Drop `clock_enable` and `lines_enable` during LANES_WAIT -> burst completes, then CLK_POST, CLK_STOP, DISABLE, IDLE; `lane_lines_enable`=0 at the end.
- **Clamp and reset.** `reg_lanes_number`=0 -> `mask`=1; `reg_lanes_number`=9 with LANES=4 -> `mask`=4'b1111. Assert `rst_n` low in LANES_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/dsi_lanes_sequencer.sv
// -----------------------------------------------------------------------------
// dsi_lanes_sequencer
//
// Power-up and HS-burst sequencer for a DSI PHY with LANES data lanes plus one
// clock lane. Turns the LP buffers on and off, starts and stops the clock lane,
// and issues one synchronised HS start pulse to every enabled data lane once
// all of them have data queued. Continuous and burst-gated clock modes are
// supported, with programmable T_CLK_PRE / T_CLK_POST intervals.
//
// Parameters:
//   LANES    number of data lanes (1..8)
//   TIMER_W  width of the timing registers and the countdown timer
//
// Ports:
//   clk_phy            PHY logic clock
//   rst_n              asynchronous active-low reset
//   lines_enable       request LP output buffers on
//   clock_enable       request clock lane active
//   clk_continuous     1: clock stays HS between bursts, 0: stopped per burst
//   reg_lanes_number   active lane count (0 -> 1, > LANES -> LANES)
//   reg_t_clk_pre      wait after clock active before first data start
//   reg_t_clk_post     wait after data end before clock stop
//   lane_pending       per-lane FIFO not empty
//   lane_active        per-lane serialiser busy
//   clk_active         clock lane is in HS
//   lane_lines_enable  per-lane LP buffer enable (the enable mask)
//   lane_start_rqst    per-lane one-cycle HS start pulse
//   clk_lines_enable   clock-lane LP buffer enable
//   clk_start_rqst     clock-lane start request
//   clk_fin_rqst       clock-lane stop request
//   lines_ready        LP buffers on
//   clock_ready        mirrors clk_active
//   lines_active       any enabled lane busy
// -----------------------------------------------------------------------------
module dsi_lanes_sequencer #(
   parameter int LANES   = 4,
   parameter int TIMER_W = 8
) (
   input  logic               clk_phy,
   input  logic               rst_n,
   input  logic               lines_enable,
   input  logic               clock_enable,
   input  logic               clk_continuous,
   input  logic [3:0]         reg_lanes_number,
   input  logic [TIMER_W-1:0] reg_t_clk_pre,
   input  logic [TIMER_W-1:0] reg_t_clk_post,
   input  logic [LANES-1:0]   lane_pending,
   input  logic [LANES-1:0]   lane_active,
   input  logic               clk_active,
   output logic [LANES-1:0]   lane_lines_enable,
   output logic [LANES-1:0]   lane_start_rqst,
   output logic               clk_lines_enable,
   output logic               clk_start_rqst,
   output logic               clk_fin_rqst,
   output logic               lines_ready,
   output logic               clock_ready,
   output logic               lines_active
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_LP_ENABLE  = 4'd1,
      S_LP_IDLE    = 4'd2,
      S_CLK_START  = 4'd3,
      S_CLK_PRE    = 4'd4,
      S_HS_READY   = 4'd5,
      S_LANES_GO   = 4'd6,
      S_LANES_WAIT = 4'd7,
      S_CLK_POST   = 4'd8,
      S_CLK_STOP   = 4'd9,
      S_DISABLE    = 4'd10
   } state_t;

   state_t             state_q, state_d;
   logic [LANES-1:0]   mask_q, mask_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               seen_q, seen_d;

   logic [3:0]         lanes_clamped;
   logic [LANES-1:0]   mask_load;
   logic               all_pending;
   logic               any_active;

   // Lane count is clamped into 1..LANES so the mask never comes out empty.
   always_comb begin
      lanes_clamped = reg_lanes_number;
      if (reg_lanes_number == 4'd0) begin
         lanes_clamped = 4'd1;
      end else if (reg_lanes_number > 4'(LANES)) begin
         lanes_clamped = 4'(LANES);
      end
   end

   // Thermometer mask: lanes 0..n-1 enabled.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_mask_load
         assign mask_load[gi] = (lanes_clamped > 4'(gi));
      end
   endgenerate

   // Disabled lanes count as "pending" so that only enabled lanes gate the start.
   assign all_pending = &(lane_pending | ~mask_q);
   assign any_active  = |(lane_active & mask_q);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      timer_d = timer_q;
      seen_d  = seen_q;

      if (any_active) begin
         seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (lines_enable) begin
               state_d = S_LP_ENABLE;
            end
         end
         S_LP_ENABLE: begin
            mask_d  = mask_load;
            state_d = S_LP_IDLE;
         end
         S_LP_IDLE: begin
            if (!lines_enable) begin
               state_d = S_DISABLE;
            end else if (clock_enable && (clk_continuous || all_pending)) begin
               state_d = S_CLK_START;
            end
         end
         S_CLK_START: begin
            if (clk_active) begin
               timer_d = reg_t_clk_pre;
               state_d = S_CLK_PRE;
            end
         end
         S_CLK_PRE: begin
            if (timer_q == '0) begin
               state_d = S_HS_READY;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_HS_READY: begin
            if (clock_enable && all_pending) begin
               state_d = S_LANES_GO;
            end else if (!clock_enable || !clk_continuous) begin
               timer_d = reg_t_clk_post;
               state_d = S_CLK_POST;
            end
         end
         S_LANES_GO: begin
            // Fresh burst: forget activity from any earlier burst.
            seen_d  = 1'b0;
            state_d = S_LANES_WAIT;
         end
         S_LANES_WAIT: begin
            // The burst is over only once the lanes have been seen busy and
            // then all gone idle; clock_enable dropping cannot cut it short.
            if (seen_q && !any_active) begin
               if (clock_enable && clk_continuous) begin
                  state_d = S_HS_READY;
               end else begin
                  timer_d = reg_t_clk_post;
                  state_d = S_CLK_POST;
               end
            end
         end
         S_CLK_POST: begin
            if (timer_q == '0) begin
               state_d = S_CLK_STOP;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_CLK_STOP: begin
            if (!clk_active) begin
               state_d = S_LP_IDLE;
            end
         end
         S_DISABLE: begin
            mask_d  = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
         timer_q <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         timer_q <= timer_d;
         seen_q  <= seen_d;
      end
   end

   // Outputs decode only registered state and mask, except the two status
   // flags that are defined as direct functions of the lane inputs.
   assign lane_lines_enable = mask_q;
   assign lane_start_rqst   = (state_q == S_LANES_GO) ? mask_q : '0;
   assign clk_lines_enable  = mask_q[0];
   assign lines_ready       = mask_q[0];
   assign clk_start_rqst    = (state_q == S_CLK_START);
   assign clk_fin_rqst      = (state_q == S_CLK_STOP);
   assign clock_ready       = clk_active;
   assign lines_active      = any_active;

endmodule

// File: tb/tb_dsi_lanes_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsi_lanes_sequencer
//
// Randomised sessions (power-up, one or more HS bursts, shutdown) drive the
// sequencer while the bench plays the part of the PHY. For every session the
// bench works out from the timing rules when each output change must appear
// (lines ready, clock request rise/fall, lane start pulse, clock stop request)
// and queues the expected output snapshot with its cycle number. A separate
// monitor watches the outputs every cycle and, on any change, pops and
// compares the next expectation.
// -----------------------------------------------------------------------------
module tb_dsi_lanes_sequencer;

   localparam int LANES   = 4;
   localparam int TIMER_W = 8;
   localparam int SW      = 2 * LANES + 2;

   logic               clk_phy;
   logic               rst_n;
   logic               lines_enable;
   logic               clock_enable;
   logic               clk_continuous;
   logic [3:0]         reg_lanes_number;
   logic [TIMER_W-1:0] reg_t_clk_pre;
   logic [TIMER_W-1:0] reg_t_clk_post;
   logic [LANES-1:0]   lane_pending;
   logic [LANES-1:0]   lane_active;
   logic               clk_active;
   logic [LANES-1:0]   lane_lines_enable;
   logic [LANES-1:0]   lane_start_rqst;
   logic               clk_lines_enable;
   logic               clk_start_rqst;
   logic               clk_fin_rqst;
   logic               lines_ready;
   logic               clock_ready;
   logic               lines_active;

   dsi_lanes_sequencer #(
      .LANES   (LANES),
      .TIMER_W (TIMER_W)
   ) dut (
      .clk_phy           (clk_phy),
      .rst_n             (rst_n),
      .lines_enable      (lines_enable),
      .clock_enable      (clock_enable),
      .clk_continuous    (clk_continuous),
      .reg_lanes_number  (reg_lanes_number),
      .reg_t_clk_pre     (reg_t_clk_pre),
      .reg_t_clk_post    (reg_t_clk_post),
      .lane_pending      (lane_pending),
      .lane_active       (lane_active),
      .clk_active        (clk_active),
      .lane_lines_enable (lane_lines_enable),
      .lane_start_rqst   (lane_start_rqst),
      .clk_lines_enable  (clk_lines_enable),
      .clk_start_rqst    (clk_start_rqst),
      .clk_fin_rqst      (clk_fin_rqst),
      .lines_ready       (lines_ready),
      .clock_ready       (clock_ready),
      .lines_active      (lines_active)
   );

   initial clk_phy = 1'b0;
   always #5 clk_phy = ~clk_phy;

   // Cycle k = the interval after the k-th rising edge.
   int cyc = 0;
   always @(posedge clk_phy) cyc <= cyc + 1;

   typedef struct {
      int             cyc;
      logic [SW-1:0]  snap;   // {lane_lines_enable, lane_start_rqst, clk_start_rqst, clk_fin_rqst}
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [LANES-1:0] m, input logic [LANES-1:0] st,
                       input logic cs, input logic cf);
      ev_t ev;
      ev.cyc  = c;
      ev.snap = {m, st, cs, cf};
      exp_q.push_back(ev);
   endtask

   function automatic int rnd(input int lo, input int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   function automatic int clampn(input int n);
      return (n < 1) ? 1 : ((n > LANES) ? LANES : n);
   endfunction

   function automatic logic [31:0] all_outs();
      return 32'({lane_lines_enable, lane_start_rqst, clk_lines_enable, clk_start_rqst,
                  clk_fin_rqst, lines_ready, clock_ready, lines_active});
   endfunction

   task automatic tick();
      @(posedge clk_phy);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin
      logic [SW-1:0]    prev;
      logic [SW-1:0]    cur;
      logic [LANES-1:0] exp_mask;
      ev_t              ev;
      prev     = '0;
      exp_mask = '0;
      forever begin
         @(negedge clk_phy);
         if (!rst_n) begin
            prev     = '0;
            exp_mask = '0;
            continue;
         end
         cur = {lane_lines_enable, lane_start_rqst, clk_start_rqst, clk_fin_rqst};
         if (cur !== prev) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_change: got 0x%0h, previous 0x%0h with nothing expected (cycle %0d)",
                        cur, prev, cyc);
            end else begin
               ev = exp_q.pop_front();
               check("event_cycle", 32'(cyc), 32'(ev.cyc));
               check("event_outputs", 32'(cur), 32'(ev.snap));
               check("lines_ready", 32'(lines_ready), 32'(ev.snap[LANES+2]));
               check("clk_lines_enable", 32'(clk_lines_enable), 32'(ev.snap[LANES+2]));
               exp_mask = ev.snap[SW-1 -: LANES];
            end
            prev = cur;
         end
         if (lane_active != '0) begin
            check("lines_active", 32'(lines_active), 32'(|(lane_active & exp_mask)));
         end
         if (clk_active) begin
            check("clock_ready", 32'(clock_ready), 32'(clk_active));
         end
      end
   end

   // ---------------------------------------------------------------- session
   task automatic run_session(input int n, input bit cont, input int nbursts,
                              input int fpre, input int fpost, input bit reset_mid);
      int               k, c, a, p, s, s1, e, f, x, pre, post;
      bit               running;
      logic [LANES-1:0] m, partial, extra;
      k = clampn(n);
      m = LANES'((1 << k) - 1);
      clk_continuous   = cont;
      reg_lanes_number = 4'(n);
      lines_enable     = 1'b1;
      c = cyc;
      push(c + 2, m, '0, 1'b0, 1'b0);
      wait_until(c + 2);
      // Later changes must not affect the mask already loaded.
      reg_lanes_number = 4'($urandom_range(15, 0));
      running = 1'b0;
      for (int b = 0; b < nbursts; b++) begin
         pre  = (fpre  >= 0) ? fpre  : rnd(0, 6);
         post = (fpost >= 0) ? fpost : rnd(0, 6);
         reg_t_clk_pre  = TIMER_W'(pre);
         reg_t_clk_post = TIMER_W'(post);
         partial = (m & ~(LANES'(1) << rnd(0, k - 1))) | (LANES'($urandom) & ~m);
         if (!running) begin
            clock_enable = 1'b1;
            lane_pending = partial;
            if (!cont) begin
               // Burst-gated clock: nothing may happen until every enabled lane has data.
               wait_until(cyc + rnd(1, 4));
               lane_pending = m | (LANES'($urandom) & ~m);
            end
            c = cyc;
            push(c + 1, m, '0, 1'b1, 1'b0);
            a = c + 1 + rnd(0, 3);
            wait_until(a);
            clk_active = 1'b1;
            push(a + 1, m, '0, 1'b0, 1'b0);
            p = cont ? a + rnd(0, pre + 5) : a;
            s = (a + pre + 3 > p + 1) ? a + pre + 3 : p + 1;
            running = 1'b1;
         end else begin
            p = cyc + rnd(0, 3);
            s = p + 1;
         end
         push(s, m, m, 1'b0, 1'b0);
         push(s + 1, m, '0, 1'b0, 1'b0);
         wait_until(p);
         lane_pending = m | (LANES'($urandom) & ~m);
         wait_until(s);
         $display("burst: lanes_req=%0d mask=%b cont=%0b pre=%0d post=%0d start_cycle=%0d",
                  n, m, cont, pre, post, s);
         reg_t_clk_pre = TIMER_W'($urandom_range(255, 0));
         lane_pending  = partial;
         extra         = LANES'($urandom) & ~m;
         lane_active   = extra;
         s1 = s + 1 + rnd(0, 2);
         e  = s1 + rnd(1, 5);
         x  = rnd(s, e);
         for (int t = s; t <= e; t++) begin
            wait_until(t);
            if (t == s1) lane_active = m | extra;
            if (t == e)  lane_active = extra;
            if (reset_mid && t == s1 + 1) begin
               #2;
               clk_active   = 1'b0;
               lane_active  = '0;
               lane_pending = '0;
               clock_enable = 1'b0;
               lines_enable = 1'b0;
               rst_n        = 1'b0;
               #1;
               check("reset_mid_burst_outputs", all_outs(), 32'd0);
               exp_q.delete();
               #4;
               rst_n = 1'b1;
               return;
            end
            if (b == nbursts - 1 && t == x) begin
               clock_enable = 1'b0;
               lines_enable = 1'b0;
            end
         end
         if (cont && clock_enable) begin
            wait_until(e + 1);
         end else begin
            push(e + 2 + post, m, '0, 1'b0, 1'b1);
            wait_until(e + 1);
            reg_t_clk_post = TIMER_W'($urandom_range(255, 0));
            f = e + 2 + post + rnd(0, 3);
            push(f + 1, m, '0, 1'b0, 1'b0);
            wait_until(f);
            clk_active = 1'b0;
            running    = 1'b0;
            if (b == nbursts - 1) begin
               push(f + 3, '0, '0, 1'b0, 1'b0);
               wait_until(f + 3);
            end else begin
               wait_until(f + 1);
            end
         end
      end
      lane_active  = '0;
      lane_pending = '0;
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      rst_n            = 1'b0;
      lines_enable     = 1'b0;
      clock_enable     = 1'b0;
      clk_continuous   = 1'b0;
      reg_lanes_number = 4'd0;
      reg_t_clk_pre    = '0;
      reg_t_clk_post   = '0;
      lane_pending     = '0;
      lane_active      = '0;
      clk_active       = 1'b0;
      #2;
      check("reset_outputs_initial", all_outs(), 32'd0);
      repeat (3) tick();
      check("reset_outputs_held", all_outs(), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

      run_session(2, 1'b1, 2, 5, 3, 1'b0);
      repeat (2) tick();
      run_session(0, 1'b0, 2, -1, 3, 1'b0);
      repeat (2) tick();
      run_session(9, 1'b0, 1, -1, -1, 1'b0);
      repeat (2) tick();
      run_session(4, 1'b0, 2, -1, -1, 1'b0);
      for (int i = 0; i < 14; i++) begin
         repeat (rnd(1, 3)) tick();
         run_session(rnd(0, 9), bit'($urandom_range(1, 0)), rnd(1, 3), -1, -1, 1'b0);
      end
      repeat (2) tick();
      run_session(4, 1'b0, 1, -1, -1, 1'b1);
      repeat (3) tick();
      run_session(rnd(0, 9), 1'b1, 2, -1, -1, 1'b0);
      repeat (10) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded its time budget (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
